regfile_2r1w_dbg: RTL and testbench
===================================

REGFILE_2R1W_DBG -- requirements
Module: regfile_2r1w_dbg

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register data width.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the write counter.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 we  input  1  SHALL be the write enable from control.
REQ-006 waddr  input  5  SHALL be the destination register index from the destination-select mux.
REQ-007 wdata  input  DATA_W  SHALL be the write-back data.
REQ-008 raddr1, raddr2  input  5 each  SHALL be the source register indices.
REQ-009 rdata1, rdata2  output  DATA_W each  SHALL be the source operand values.
REQ-010 dbg_step  input  1  SHALL be a synchronized, level-type board button; each 0->1 transition advances the debug index.
REQ-011 dbg_idx  output  5  SHALL be the register index currently shown on the board display.
REQ-012 dbg_data  output  DATA_W  SHALL be the stored contents of register dbg_idx.
REQ-013 wr_cnt  output  CNT_W  SHALL be the count of effective register writes since reset.

Function
REQ-014 Storage SHALL be 32 registers of DATA_W bits; register 0 SHALL always read 0 and SHALL never be written.
REQ-015 An effective write SHALL occur on a rising clk edge when we=1 and waddr!=0; wdata is stored at waddr.
REQ-016 we=1 with waddr=0 SHALL change no state, including wr_cnt.
REQ-017 rdata1 and rdata2 SHALL be combinational; zero cycles of latency from raddr.
REQ-018 Write-through bypass: when we=1, waddr!=0 and raddrN==waddr, rdataN SHALL equal wdata in the same cycle.
REQ-019 With raddrN=0, rdataN SHALL be 0 regardless of we/waddr/wdata.
REQ-020 Both read ports SHALL be independent; raddr1==raddr2 SHALL return identical values.
REQ-021 A 1-bit flop SHALL register dbg_step; a rising edge is detected when dbg_step=1 and the flop=0.
REQ-022 On each detected rising edge dbg_idx SHALL increment by 1 at the next clk edge, wrapping 31->0.
REQ-023 Holding dbg_step high for any number of cycles SHALL advance dbg_idx exactly once.
REQ-024 dbg_data SHALL be combinational from stored contents only; no bypass.
REQ-025 dbg_data SHALL show the new value in the cycle after a write to dbg_idx.
REQ-026 wr_cnt SHALL increment by 1 per effective write and SHALL saturate at all-ones.
REQ-027 A write and a debug-index advance in the same cycle SHALL both take effect.

Reset
REQ-028 While rst_n=0, all 32 registers, dbg_idx, wr_cnt and the dbg_step flop SHALL be 0, independent of clk.
REQ-029 Reset asserted mid-operation SHALL discard any write pending on that edge.
REQ-030 After rst_n deasserts, the first effective write SHALL occur on the first rising clk edge with rst_n=1.
REQ-031 If dbg_step is already high at reset release, one advance SHALL occur: the cleared flop sees a rising edge.

Verification
REQ-032 Write-then-read: we=1, waddr=5, wdata=0xDEADBEEF for one edge; then raddr1=5 -> rdata1=0xDEADBEEF, wr_cnt=1.
REQ-033 Register zero: we=1, waddr=0, wdata=0xFFFFFFFF for one edge; raddr2=0 -> rdata2=0, wr_cnt unchanged.
REQ-034 Bypass: reg 7=0x11; in the same cycle drive we=1, waddr=7, wdata=0x22, raddr1=7 -> rdata1=0x22 before the edge, and dbg_data for idx 7=0x11 until the edge.
REQ-035 Debug scan: pulse dbg_step 32 times, each high for 3 cycles -> dbg_idx goes 1..31 then 0; each pulse advances once.
REQ-036 Async reset mid-run: fill regs 1..31 with their index, pulse rst_n low between edges -> all rdata, dbg_data, dbg_idx and wr_cnt are 0 immediately.
REQ-037 Saturation (CNT_W=4 override): 20 effective writes -> wr_cnt=15.

Source files
------------

// File: rtl/regfile_2r1w_dbg.sv
// Two-read / one-write register file with a board debug viewer.
//
// Thirty-two DATA_W-bit registers, register 0 hard-wired to zero. Two
// combinational read ports with write-through bypass, one synchronous write
// port, a saturating count of effective writes, and a debug index stepped by
// a synchronized push button whose register is shown on dbg_data.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   we, waddr, wdata  write port (waddr 0 is ignored)
//   raddr1/2, rdata1/2  combinational read ports with bypass
//   dbg_step          level button; each 0->1 advances dbg_idx
//   dbg_idx, dbg_data register shown on the board and its stored value
//   wr_cnt            effective writes since reset, saturating
module regfile_2r1w_dbg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [4:0]        raddr1,
  input  logic [4:0]        raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              dbg_step,
  output logic [4:0]        dbg_idx,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam int unsigned AW    = 5;
  localparam int unsigned NREGS = 32;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              step_q;
  logic              step_d;
  logic [AW-1:0]     dbg_idx_q;
  logic [AW-1:0]     dbg_idx_d;
  logic [CNT_W-1:0]  wr_cnt_q;
  logic [CNT_W-1:0]  wr_cnt_d;

  logic              wr_en_c;
  logic              step_rise_c;

  // A write to register 0 is a no-op everywhere, including the counter.
  assign wr_en_c     = we && (waddr != '0);
  assign step_rise_c = dbg_step && !step_q;

  // Register array next state; entry 0 is pinned to zero.
  always_comb begin
    regs_d = regs_q;
    if (wr_en_c) begin
      regs_d[waddr] = wdata;
    end
    regs_d[0] = '0;
  end

  // Debug edge detector and index; wraps naturally at 5 bits.
  always_comb begin
    step_d    = dbg_step;
    dbg_idx_d = dbg_idx_q + AW'(step_rise_c);
  end

  // Saturating effective-write counter.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (wr_en_c && (wr_cnt_q != '1)) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      step_q    <= 1'b0;
      dbg_idx_q <= '0;
      wr_cnt_q  <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      step_q    <= step_d;
      dbg_idx_q <= dbg_idx_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  // Read ports: zero for index 0, bypass the in-flight write, else storage.
  always_comb begin
    rdata1 = regs_q[raddr1];
    if (raddr1 == '0) begin
      rdata1 = '0;
    end else if (wr_en_c && (waddr == raddr1)) begin
      rdata1 = wdata;
    end
  end

  always_comb begin
    rdata2 = regs_q[raddr2];
    if (raddr2 == '0) begin
      rdata2 = '0;
    end else if (wr_en_c && (waddr == raddr2)) begin
      rdata2 = wdata;
    end
  end

  // The debug view shows committed contents only, never the bypass.
  assign dbg_data = regs_q[dbg_idx_q];
  assign dbg_idx  = dbg_idx_q;
  assign wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_regfile_2r1w_dbg.sv
// Self-checking bench for regfile_2r1w_dbg: directed scenarios plus random
// traffic, expectations from an array-based model pushed to a scoreboard and
// compared by an independent monitor on the falling clock edge.
module tb_regfile_2r1w_dbg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;
  logic        dbg_step = 1'b0;

  logic [31:0] rdata1, rdata2, dbg_data;
  logic [4:0]  dbg_idx;
  logic [15:0] wr_cnt;
  logic [31:0] s_rdata1, s_rdata2, s_dbg_data;
  logic [4:0]  s_dbg_idx;
  logic [3:0]  s_wr_cnt;

  always #5 clk = ~clk;

  regfile_2r1w_dbg dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .dbg_step(dbg_step), .dbg_idx(dbg_idx), .dbg_data(dbg_data), .wr_cnt(wr_cnt)
  );

  regfile_2r1w_dbg #(.DATA_W(32), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(s_rdata1), .rdata2(s_rdata2),
    .dbg_step(dbg_step), .dbg_idx(s_dbg_idx), .dbg_data(s_dbg_data), .wr_cnt(s_wr_cnt)
  );

  typedef struct {
    string       name;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] dd;
    logic [4:0]  di;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: plain array, integer counter, integer index.
  logic [31:0] m_mem [32];
  int          m_cnt;
  int          m_idx;
  bit          m_prev;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_cnt  = 0;
    m_idx  = 0;
    m_prev = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] ra);
    if (ra == 5'd0) return 32'd0;
    if (we && (waddr == ra)) return wdata;
    return m_mem[ra];
  endfunction

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s.%s actual=%h expected=%h t=%0t", nm, fld, act, exp_v, $time);
    end
  endtask

  // Monitor: compare whatever the stimulus has queued for this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.name, "rdata1",   rdata1,           e.r1);
      chk(e.name, "rdata2",   rdata2,           e.r2);
      chk(e.name, "dbg_data", dbg_data,         e.dd);
      chk(e.name, "dbg_idx",  32'(dbg_idx),     32'(e.di));
      chk(e.name, "wr_cnt",   32'(wr_cnt),      32'(e.cnt));
      chk(e.name, "wr_cnt4",  32'(s_wr_cnt),    32'(e.cnt4));
      chk(e.name, "sat_rd1",  s_rdata1,         e.r1);
    end
  end

  // One clock cycle of stimulus; expectation reflects state before the edge.
  task automatic cycle(input bit w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input bit st, input bit rn, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    we = w; waddr = wa; wdata = wd; raddr1 = r1; raddr2 = r2;
    dbg_step = st; rst_n = rn;
    if (!rn) model_reset();
    e.name = nm;
    e.r1   = m_read(r1);
    e.r2   = m_read(r2);
    e.dd   = m_mem[m_idx];
    e.di   = 5'(m_idx);
    e.cnt  = 16'((m_cnt > 65535) ? 65535 : m_cnt);
    e.cnt4 = 4'((m_cnt > 15) ? 15 : m_cnt);
    sb.push_back(e);
    if (rn) begin
      if (w && (wa != 5'd0)) begin
        m_mem[wa] = wd;
        m_cnt++;
      end
      if (st && !m_prev) m_idx = (m_idx + 1) % 32;
      m_prev = st;
    end
  endtask

  initial begin
    bit          w, st, rn;
    logic [4:0]  wa, r1, r2;
    model_reset();

    // Reset state; a write held during reset must be discarded.
    cycle(1'b1, 5'd3, 32'h1234_5678, 5'd3, 5'd1, 1'b0, 1'b0, "reset");
    cycle(1'b1, 5'd3, 32'h1234_5678, 5'd3, 5'd2, 1'b0, 1'b0, "reset_hold");

    // First edge after release writes; bypass then stored read.
    cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd3, 1'b0, 1'b1, "first_write");
    cycle(1'b0, 5'd0, 32'h0,         5'd5, 5'd5, 1'b0, 1'b1, "wr_then_rd");

    // Register zero is never written and never counted.
    cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b0, 1'b1, "reg0_write");
    cycle(1'b0, 5'd0, 32'h0,         5'd5, 5'd0, 1'b0, 1'b1, "reg0_read");

    // Bypass vs. debug view on register 7.
    cycle(1'b1, 5'd7, 32'h11, 5'd1, 5'd2, 1'b0, 1'b1, "set_r7");
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 1'b1, 1'b1, "to_idx7_hi");
      cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 1'b0, 1'b1, "to_idx7_lo");
    end
    cycle(1'b1, 5'd7, 32'h22, 5'd7, 5'd7, 1'b0, 1'b1, "bypass");
    cycle(1'b0, 5'd0, 32'h0,  5'd7, 5'd0, 1'b0, 1'b1, "dbg_after_wr");

    // Debug scan: 32 pulses, each held three cycles.
    for (int p = 0; p < 32; p++) begin
      for (int h = 0; h < 3; h++)
        cycle(1'b0, 5'd0, 32'h0, 5'(p), 5'(31 - p), 1'b1, 1'b1, "scan_hi");
      cycle(1'b0, 5'd0, 32'h0, 5'(p), 5'(31 - p), 1'b0, 1'b1, "scan_lo");
    end

    // Write and advance together.
    cycle(1'b1, 5'd8, 32'hCAFE_0008, 5'd8, 5'd7, 1'b1, 1'b1, "wr_and_step");
    cycle(1'b0, 5'd0, 32'h0,         5'd8, 5'd7, 1'b0, 1'b1, "wr_and_step2");

    // Fill 1..31 with their index, then reset mid-run.
    for (int r = 1; r < 32; r++)
      cycle(1'b1, 5'(r), 32'(r), 5'(r), 5'(32 - r), 1'b0, 1'b1, "fill");
    cycle(1'b1, 5'd9, 32'hABCD, 5'd4, 5'd31, 1'b0, 1'b0, "async_rst");
    cycle(1'b1, 5'd9, 32'hABCD, 5'd9, 5'd1,  1'b1, 1'b0, "rst_step_hi");
    // Button already high at release advances exactly once.
    cycle(1'b0, 5'd0, 32'h0, 5'd9, 5'd4, 1'b1, 1'b1, "release_step");
    cycle(1'b0, 5'd0, 32'h0, 5'd9, 5'd4, 1'b1, 1'b1, "release_hold");
    cycle(1'b0, 5'd0, 32'h0, 5'd9, 5'd4, 1'b0, 1'b1, "release_low");

    // Twenty effective writes saturate the narrow counter.
    for (int k = 0; k < 20; k++)
      cycle(1'b1, 5'(1 + (k % 31)), $urandom, 5'(k), 5'(k + 1), 1'b0, 1'b1, "sat_fill");
    cycle(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b0, 1'b1, "sat_check");

    // Random traffic with occasional resets.
    st = 1'b0;
    for (int n = 0; n < 800; n++) begin
      w  = ($urandom % 4) != 0;
      wa = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom);
      r1 = (($urandom % 3) == 0) ? wa : 5'($urandom);
      r2 = (($urandom % 3) == 0) ? wa : 5'($urandom);
      if (($urandom % 3) == 0) st = ~st;
      rn = ($urandom % 80) != 0;
      if (!rn && (r1 == wa)) r1 = wa + 5'd1;
      if (!rn && (r2 == wa)) r2 = wa + 5'd2;
      cycle(w, wa, $urandom, r1, r2, st, rn, "random");
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
